// File: rtl/countdown_pkg.sv
// Shared types and default parameters for the countdown timer.
package countdown_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_PRESCALE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Count-step strobe generator: one tick every PRESCALE enabled cycles.
// The phase only advances while enabled, so a paused timer keeps its phase.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_reg;

    assign tick = enable && (phase_reg == LAST);

    // Phase counter: cleared on request, wraps to zero on each tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_reg <= '0;
        end else if (clear) begin
            phase_reg <= '0;
        end else if (enable) begin
            phase_reg <= tick ? '0 : phase_reg + PW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop/pause control and an expiry pulse.
// Build option: define COUNTDOWN_AUTO_RELOAD_EN to honour auto_reload
// (periodic mode); otherwise the timer is one-shot and auto_reload is ignored.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             periodic;
    logic             ps_enable;
    logic             ps_clear;
    logic             tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign periodic = auto_reload;
`else
    logic unused_auto_reload;
    assign unused_auto_reload = auto_reload;
    assign periodic           = 1'b0;
`endif

    // Prescaler runs only while counting with no higher-priority control
    // active; it restarts from phase zero on load and on a fresh start.
    assign ps_enable = (state_reg == RUN) && !load && !stop;
    assign ps_clear  = load ||
                       ((state_reg == IDLE) && start && !stop && (cnt_reg != '0));

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .enable    (ps_enable),
        .clear     (ps_clear),
        .tick      (tick)
    );

    // Next-state and next-output logic; priority is load, then stop, then start.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        reload_next = reload_reg;
        done_next   = 1'b0;
        if (load) begin
            cnt_next    = load_val;
            reload_next = load_val;
            state_next  = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !stop) begin
                        if (cnt_reg != '0) begin
                            state_next = RUN;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_next = PAUSE;
                    end else if (tick) begin
                        if (cnt_reg > WIDTH'(1)) begin
                            cnt_next = cnt_reg - WIDTH'(1);
                        end else begin
                            // Expiry: reload in periodic mode, otherwise stop at zero.
                            done_next = 1'b1;
                            if (periodic && (reload_reg != '0)) begin
                                cnt_next = reload_reg;
                            end else begin
                                cnt_next   = '0;
                                state_next = IDLE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset aborts any count without a done pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            reload_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            reload_reg <= reload_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign cnt  = cnt_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: two instances (PRESCALE 1 and 4)
// share the stimulus; a behavioural model queues expected outputs per cycle
// and a monitor compares them on the falling edge.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] cnt_a, cnt_b;
    logic       busy_a, busy_b, done_a, done_b;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(8), .PRESCALE(1)) u_p1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .cnt(cnt_a), .busy(busy_a), .done(done_a)
    );

    countdown_timer #(.WIDTH(8), .PRESCALE(4)) u_p4 (
        .sys_clk(clk), .sys_rst_n(rst_n), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .cnt(cnt_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        int         n;
        logic [7:0] c0, c1;
        logic       b0, b1, d0, d1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    // Behavioural model: mode 0 idle, 1 counting, 2 paused; left = cycles to next step
    int pres[2] = '{1, 4};
    int m_mode[2], m_cnt[2], m_rel[2], m_left[2], m_done[2];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn %0d: got %0d expected %0d", nm, txn, act, exp);
        end
    endtask

    task automatic model_step(int k, bit r, bit ld, int lv, bit st, bit sp, bit ar);
        bit per;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        per = ar;
`else
        per = ar & 1'b0;
`endif
        m_done[k] = 0;
        if (!r) begin
            m_mode[k] = 0; m_cnt[k] = 0; m_rel[k] = 0; m_left[k] = pres[k];
        end else if (ld) begin
            m_cnt[k] = lv; m_rel[k] = lv; m_mode[k] = 0; m_left[k] = pres[k];
        end else if (sp) begin
            if (m_mode[k] == 1) m_mode[k] = 2;
        end else if (st && m_mode[k] == 0) begin
            if (m_cnt[k] != 0) begin
                m_mode[k] = 1; m_left[k] = pres[k];
            end else begin
                m_done[k] = 1;
            end
        end else if (st && m_mode[k] == 2) begin
            m_mode[k] = 1;
        end else if (m_mode[k] == 1) begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
                m_left[k] = pres[k];
                if (m_cnt[k] > 1) begin
                    m_cnt[k] = m_cnt[k] - 1;
                end else begin
                    m_done[k] = 1;
                    if (per && m_rel[k] != 0) begin
                        m_cnt[k] = m_rel[k];
                    end else begin
                        m_cnt[k] = 0; m_mode[k] = 0;
                    end
                end
            end
        end
    endtask

    // One clock cycle of stimulus; the expected response is queued after the edge.
    task automatic cyc(bit r, bit ld, int lv, bit st, bit sp, bit ar);
        exp_t e;
        rst_n = r; load = ld; load_val = 8'(lv); start = st; stop = sp; auto_reload = ar;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, r, ld, lv, st, sp, ar);
        e.n  = txn;
        e.c0 = 8'(m_cnt[0]); e.c1 = 8'(m_cnt[1]);
        e.b0 = (m_mode[0] != 0); e.b1 = (m_mode[1] != 0);
        e.d0 = m_done[0][0]; e.d1 = m_done[1][0];
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n, bit ar);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, ar);
    endtask

    // Asynchronous reset between edges must clear outputs immediately.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("async_cnt_p1", 32'(cnt_a), 0);
        chk("async_busy_p1", 32'(busy_a), 0);
        chk("async_done_p1", 32'(done_a), 0);
        chk("async_cnt_p4", 32'(cnt_b), 0);
        chk("async_busy_p4", 32'(busy_b), 0);
        chk("async_done_p4", 32'(done_b), 0);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pop one expectation per cycle and compare both instances.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                $display("txn %0d: p1 cnt=%0d busy=%0d done=%0d | p4 cnt=%0d busy=%0d done=%0d",
                         e.n, cnt_a, busy_a, done_a, cnt_b, busy_b, done_b);
                chk("cnt_p1", 32'(cnt_a), 32'(e.c0));
                chk("busy_p1", 32'(busy_a), 32'(e.b0));
                chk("done_p1", 32'(done_a), 32'(e.d0));
                chk("cnt_p4", 32'(cnt_b), 32'(e.c1));
                chk("busy_p4", 32'(busy_b), 32'(e.b1));
                chk("done_p4", 32'(done_b), 32'(e.d1));
                txn++;
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) model_step(k, 0, 0, 0, 0, 0, 0);
        // Reset state
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        // One-shot countdown from 5
        cyc(1, 1, 5, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        idle(8, 0);
        // Periodic mode from 3 (one-shot when the option is not built in)
        cyc(1, 1, 3, 0, 0, 1);
        cyc(1, 0, 0, 1, 0, 1);
        idle(12, 1);
        cyc(1, 1, 0, 0, 0, 0);
        // Pause and resume
        cyc(1, 1, 6, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        idle(2, 0);
        cyc(1, 0, 0, 0, 1, 0);
        idle(3, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0, 0);
        idle(3, 0);
        // Load mid-run, then load+stop+start together
        cyc(1, 0, 0, 1, 0, 0);
        idle(1, 0);
        cyc(1, 1, 9, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        idle(2, 0);
        cyc(1, 1, 7, 1, 1, 0);
        idle(2, 0);
        // Start with zero count, and stop beating start in idle
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 1, 0);
        idle(1, 0);
        // Prescaled count to expiry, then async reset mid-count
        cyc(1, 1, 2, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        idle(12, 0);
        cyc(1, 1, 2, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        idle(5, 0);
        async_reset();
        idle(2, 0);
        // Periodic with reload 1 (back-to-back expiries when enabled)
        cyc(1, 1, 1, 0, 0, 1);
        cyc(1, 0, 0, 1, 0, 1);
        idle(6, 1);
        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            cyc(1, ($urandom % 14) == 0, int'($urandom_range(0, 6)),
                ($urandom % 4) == 0, ($urandom % 9) == 0, ($urandom % 3) != 0);
            if (($urandom % 120) == 0) async_reset();
        end
        idle(2, 0);
        // Drain with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
